// File: rtl/voxel_column_engine.sv
// Purpose: builds NUM_CHANNELS pixel columns of NUM_ROWS rows for one panel angle, one row per cycle, in a selectable shape mode.
// Latency: request accepted at edge 0, rows written at edges 1..NUM_ROWS, out_valid from the cycle after edge NUM_ROWS.
// Backpressure: finished columns are held while out_ready=0; no new request is taken until the out_valid/out_ready handshake.
//
// Ports:
//   clk_in, rst_in          clock, synchronous active-high reset
//   req_valid / req_ready   request handshake; theta, column_index, mode, radius, color sampled on accept
//   out_valid / out_ready   result handshake; columns holds the generated pixel columns
module voxel_column_engine #(
  parameter int SCAN_RATE    = 32,
  parameter int NUM_ROWS     = 64,
  parameter int RGB_RES      = 9,
  parameter int THETA_RES    = 27,
  parameter int NUM_CHANNELS = 2
) (
  input  logic                                                  clk_in,
  input  logic                                                  rst_in,
  input  logic                                                  req_valid,
  output logic                                                  req_ready,
  input  logic [THETA_RES-1:0]                                  theta,
  input  logic [NUM_CHANNELS-1:0][$clog2(SCAN_RATE)-1:0]        column_index,
  input  logic [1:0]                                            mode,
  input  logic [$clog2(NUM_ROWS)-1:0]                           radius,
  input  logic [RGB_RES-1:0]                                    color,
  output logic                                                  out_valid,
  input  logic                                                  out_ready,
  output logic [NUM_CHANNELS-1:0][NUM_ROWS-1:0][RGB_RES-1:0]    columns
);

  localparam int CW  = $clog2(SCAN_RATE);
  localparam int RW  = $clog2(NUM_ROWS);
  // Magnitudes carry one spare bit so |d|, |z| and radius share one unsigned width.
  localparam int AW  = ((CW > RW) ? CW : RW) + 1;
  localparam int SQW = 2 * AW;

  localparam logic [AW-1:0] HALF_COL = AW'(SCAN_RATE / 2);
  localparam logic [AW-1:0] HALF_ROW = AW'(NUM_ROWS / 2);
  localparam logic [RW-1:0] LAST_ROW = RW'(NUM_ROWS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUILD = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                                              state_q, state_d;
  logic [RW-1:0]                                       row_q, row_d;
  logic [NUM_CHANNELS-1:0][CW-1:0]                     col_q, col_d;
  logic [1:0]                                          mode_q, mode_d;
  logic [RW-1:0]                                       radius_q, radius_d;
  logic [RGB_RES-1:0]                                  color_q, color_d;
  // Only the top RW bits of theta select the helix row, so only they are kept.
  logic [RW-1:0]                                       theta_top_q, theta_top_d;
  logic [NUM_CHANNELS-1:0][NUM_ROWS-1:0][RGB_RES-1:0]  columns_q, columns_d;

  // Row-dependent terms are shared by all channels.
  logic [AW-1:0]  row_x, az, rad_x;
  logic [SQW-1:0] az_sq, rad_sq;
  logic           helix_row;
  logic [NUM_CHANNELS-1:0][RGB_RES-1:0] pix;

  assign row_x     = AW'(row_q);
  assign az        = (row_x >= HALF_ROW) ? (row_x - HALF_ROW) : (HALF_ROW - row_x);
  assign rad_x     = AW'(radius_q);
  assign az_sq     = SQW'(az) * SQW'(az);
  assign rad_sq    = SQW'(rad_x) * SQW'(rad_x);
  assign helix_row = (row_q == theta_top_q);

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    logic [AW-1:0]  col_x, ad;
    logic [SQW-1:0] s, err;
    logic           lit;

    assign col_x = AW'(col_q[c]);
    assign ad    = (col_x >= HALF_COL) ? (col_x - HALF_COL) : (HALF_COL - col_x);
    assign s     = SQW'(ad) * SQW'(ad) + az_sq;
    // Shell thickness test |s - r^2| <= r done on magnitudes to stay unsigned.
    assign err   = (s >= rad_sq) ? (s - rad_sq) : (rad_sq - s);

    always_comb begin
      lit = 1'b0;
      case (mode_q)
        2'd0:    lit = (ad == rad_x);
        2'd1:    lit = (err <= SQW'(rad_x));
        2'd2:    lit = (ad == rad_x) && helix_row;
        2'd3:    lit = (ad <= rad_x) && (az <= rad_x);
        default: lit = 1'b0;
      endcase
    end

    assign pix[c] = lit ? color_q : '0;
  end

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    mode_d      = mode_q;
    radius_d    = radius_q;
    color_d     = color_q;
    theta_top_d = theta_top_q;
    columns_d   = columns_q;
    req_ready   = 1'b0;
    out_valid   = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          col_d       = column_index;
          mode_d      = mode;
          radius_d    = radius;
          color_d     = color;
          theta_top_d = theta[THETA_RES-1 -: RW];
          columns_d   = '0;
          row_d       = '0;
          state_d     = S_BUILD;
        end
      end
      S_BUILD: begin
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
          columns_d[ch][row_q] = pix[ch];
        end
        row_d = row_q + RW'(1);
        if (row_q == LAST_ROW) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      mode_q      <= '0;
      radius_q    <= '0;
      color_q     <= '0;
      theta_top_q <= '0;
      columns_q   <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      mode_q      <= mode_d;
      radius_q    <= radius_d;
      color_q     <= color_d;
      theta_top_q <= theta_top_d;
      columns_q   <= columns_d;
    end
  end

  assign columns = columns_q;

endmodule

// File: tb/tb_voxel_column_engine.sv
// Purpose: randomized and directed requests into voxel_column_engine, checked by a scoreboard against a shape model.
// Latency: expects out_valid 65 cycles after accept at default parameters.
// Backpressure: drives out_ready random, forced high, or forced low to hold results.
module tb_voxel_column_engine;

  localparam int SCAN = 32;
  localparam int ROWS = 64;
  localparam int RGB  = 9;
  localparam int TH   = 27;
  localparam int NCH  = 2;
  localparam int LAT  = 65;

  typedef logic [NCH-1:0][ROWS-1:0][RGB-1:0] cols_t;
  typedef struct {
    cols_t cols;
    int    acc;
  } exp_t;

  logic                 clk_in = 1'b0;
  logic                 rst_in = 1'b1;
  logic                 req_valid = 1'b0;
  logic                 req_ready;
  logic [TH-1:0]        theta = '0;
  logic [NCH-1:0][4:0]  column_index = '0;
  logic [1:0]           mode = '0;
  logic [5:0]           radius = '0;
  logic [RGB-1:0]       color = '0;
  logic                 out_valid;
  logic                 out_ready;
  cols_t                columns;

  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;
  int   rdy_sel = 1;      // 0 random, 1 always high, 2 always low
  logic rnd_rdy = 1'b1;
  logic prev_ov = 1'b0;
  int   lat;
  exp_t sbq[$];

  assign out_ready = (rdy_sel == 1) || ((rdy_sel == 0) && rnd_rdy);

  voxel_column_engine dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .theta        (theta),
    .column_index (column_index),
    .mode         (mode),
    .radius       (radius),
    .color        (color),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .columns      (columns)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    cyc     <= cyc + 1;
    rnd_rdy <= ($urandom_range(0, 3) != 0);
  end

  // Shape model straight from the geometric rules, using signed ints.
  function automatic cols_t model(input int c0, input int c1, input int md, input int r,
                                  input int tht, input logic [RGB-1:0] clr);
    cols_t m;
    int    cs[2];
    int    d, z, ad, az, s;
    bit    lit;
    m = '0;
    cs[0] = c0;
    cs[1] = c1;
    for (int ch = 0; ch < NCH; ch++) begin
      for (int row = 0; row < ROWS; row++) begin
        d  = cs[ch] - SCAN / 2;
        z  = row - ROWS / 2;
        ad = (d < 0) ? -d : d;
        az = (z < 0) ? -z : z;
        s  = d * d + z * z;
        case (md)
          0:       lit = (ad == r);
          1:       lit = ((s - r * r) <= r) && ((r * r - s) <= r);
          2:       lit = (ad == r) && (row == tht);
          default: lit = (ad <= r) && (az <= r);
        endcase
        if (lit) m[ch][row] = clr;
      end
    end
    return m;
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_cols_zero(input string nm);
    nvec++;
    if (columns !== '0) begin
      nerr++;
      $display("FAIL %s: columns not zero, got %h", nm, columns);
    end
  endtask

  task automatic send(input logic [NCH-1:0][4:0] ci, input logic [1:0] md, input logic [5:0] r,
                      input logic [TH-1:0] th, input logic [RGB-1:0] clr, input bit push,
                      output int waited);
    exp_t e;
    column_index = ci;
    mode         = md;
    radius       = r;
    theta        = th;
    color        = clr;
    req_valid    = 1'b1;
    waited       = 0;
    while (!req_ready && waited < 300) begin
      tick();
      waited++;
    end
    if (!req_ready) begin
      nvec++;
      nerr++;
      $display("FAIL req_accept_timeout: req_ready stayed 0 for %0d cycles", waited);
      req_valid = 1'b0;
      return;
    end
    e.cols = model(int'(ci[0]), int'(ci[1]), int'(md), int'(r), int'(th[TH-1 -: 6]), clr);
    e.acc  = cyc;
    if (push) sbq.push_back(e);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 3000) begin
      tick();
      n++;
    end
    nvec++;
    if (sbq.size() != 0) begin
      nerr++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  // Monitor: compares presented columns with the head of the scoreboard every valid cycle, pops on handshake.
  always @(negedge clk_in) begin
    if (!rst_in && out_valid) begin
      if (sbq.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_output: out_valid=1 with no request outstanding");
      end else begin
        if (!prev_ov) begin
          lat = cyc - sbq[0].acc;
          nvec++;
          if (lat != LAT) begin
            nerr++;
            $display("FAIL latency: got %0d cycles expected %0d", lat, LAT);
          end
        end
        for (int ch = 0; ch < NCH; ch++) begin
          nvec++;
          if (columns[ch] !== sbq[0].cols[ch]) begin
            nerr++;
            $display("FAIL column_ch%0d: got %h expected %h", ch, columns[ch], sbq[0].cols[ch]);
          end
        end
        nvec++;
        if (req_ready !== 1'b0) begin
          nerr++;
          $display("FAIL req_ready_in_done: got %b expected 0", req_ready);
        end
        if (out_ready) void'(sbq.pop_front());
      end
    end
    prev_ov = rst_in ? 1'b0 : out_valid;
  end

  initial begin
    logic [NCH-1:0][4:0] ci;
    int w;

    // Reset
    rst_in = 1'b1;
    tick();
    tick();
    chk("reset_req_ready", 64'(req_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk_cols_zero("reset_columns");
    rst_in = 1'b0;
    tick();

    // Directed shapes
    rdy_sel = 1;
    ci[0] = 5'd21; ci[1] = 5'd11;
    send(ci, 2'd0, 6'd5, 27'($urandom), 9'h1FF, 1'b1, w);
    ci[0] = 5'd3;  ci[1] = 5'd16;
    send(ci, 2'd0, 6'd5, 27'($urandom), 9'h1FF, 1'b1, w);
    ci[0] = 5'd24; ci[1] = 5'd16;
    send(ci, 2'd1, 6'd8, 27'($urandom), 9'h0AA, 1'b1, w);
    ci[0] = 5'd21; ci[1] = 5'd12;
    send(ci, 2'd2, 6'd5, {6'd10, 21'($urandom)}, 9'h133, 1'b1, w);
    ci[0] = 5'd16; ci[1] = 5'd16;
    send(ci, 2'd0, 6'd0, 27'($urandom), 9'h001, 1'b1, w);
    send(ci, 2'd1, 6'd0, 27'($urandom), 9'h155, 1'b1, w);
    drain();

    // Randomized requests with random consumer stalls
    rdy_sel = 0;
    for (int i = 0; i < 14; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      ci[0] = 5'($urandom_range(0, SCAN - 1));
      ci[1] = ($urandom_range(0, 4) == 0) ? ci[0] : 5'($urandom_range(0, SCAN - 1));
      send(ci, 2'($urandom_range(0, 3)),
           ($urandom_range(0, 6) == 0) ? 6'd0 : 6'($urandom_range(1, 20)),
           27'($urandom), 9'($urandom), 1'b1, w);
    end
    drain();

    // Backpressure: hold result while new requests knock
    rdy_sel = 2;
    ci[0] = 5'd19; ci[1] = 5'd9;
    send(ci, 2'd3, 6'd6, 27'($urandom), 9'h0F0, 1'b1, w);
    w = 0;
    while (!out_valid && w < 200) begin
      tick();
      w++;
    end
    chk("bp_out_valid_rise", 64'(out_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      req_valid    = 1'b1;
      column_index = {5'($urandom), 5'($urandom)};
      mode         = 2'($urandom);
      radius       = 6'($urandom);
      color        = 9'($urandom);
      theta        = 27'($urandom);
      tick();
      chk("bp_out_valid_held", 64'(out_valid), 64'd1);
      chk("bp_req_ready_low", 64'(req_ready), 64'd0);
    end
    rdy_sel   = 1;
    req_valid = 1'b0;
    tick();
    chk("bp_out_valid_drop", 64'(out_valid), 64'd0);
    chk("bp_req_ready_back", 64'(req_ready), 64'd1);
    ci[0] = 5'd3; ci[1] = 5'd16;
    send(ci, 2'd0, 6'd5, 27'($urandom), 9'h1FF, 1'b1, w);
    chk("bp_accept_wait", 64'(w), 64'd0);
    drain();

    // Reset in the middle of a build
    ci[0] = 5'd18; ci[1] = 5'd7;
    send(ci, 2'd3, 6'd4, 27'($urandom), 9'h0C3, 1'b0, w);
    repeat (19) tick();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    chk("midrst_req_ready", 64'(req_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk_cols_zero("midrst_columns");
    ci[0] = 5'd18; ci[1] = 5'd28;
    send(ci, 2'd3, 6'd4, 27'($urandom), 9'h0C3, 1'b1, w);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
